rxdatreg: RTL and testbench
===========================

RXDATREG -- requirements
Module: rxdatreg

Interface
REQ-001 SHALL have parameter DATA_W, default 8, number of data bits per frame.
REQ-002 SHALL have port i_Pclk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port i_Reset_n  input  1  asynchronous reset, active-low.
REQ-004 SHALL have port i_Sclk_En  input  1  one-cycle bit-sample strobe from the USRT bit clock.
REQ-005 SHALL have port i_Rx  input  1  serial line; idle high.
REQ-006 SHALL have port i_Read  input  1  one-cycle host read strobe.
REQ-007 SHALL have port o_Data  output  DATA_W  last accepted byte.
REQ-008 SHALL have port o_Ready  output  1  unread byte held in o_Data.
REQ-009 SHALL have port o_Busy  output  1  frame reception in progress.
REQ-010 SHALL have port o_Overrun  output  1  sticky; a completed byte was dropped.
REQ-011 SHALL have port o_Frame_Err  output  1  sticky; stop bit sampled low.

Function
REQ-012 SHALL sample i_Rx only in cycles where i_Sclk_En=1; other cycles hold state.
REQ-013 SHALL implement states IDLE, DATA, PARITY (macro only), STOP.
REQ-014 IDLE -> DATA on a sample of i_Rx=0 (start bit); a sample of 1 stays IDLE.
REQ-015 DATA: shift DATA_W samples LSB first; bit counter 0..DATA_W-1; after the last bit -> PARITY if enabled, else STOP.
REQ-016 STOP: on sample, always -> IDLE; stop=1 completes frame, stop=0 sets o_Frame_Err and discards the byte.
REQ-017 o_Busy SHALL be 1 in every state except IDLE.
REQ-018 On frame completion with o_Ready=0: load o_Data and set o_Ready in the cycle after the stop-bit sample edge (1-cycle latency).
REQ-019 On frame completion with o_Ready=1 and i_Read=0: keep old o_Data, set o_Overrun.
REQ-020 i_Read with o_Ready=1 SHALL clear o_Ready, o_Overrun and o_Frame_Err next cycle; o_Data holds its value.
REQ-021 i_Read in the same cycle as completion: load new byte, o_Ready stays 1, no overrun, error flags cleared then re-evaluated for the new frame (new frame's error wins).
REQ-022 i_Read with o_Ready=0 SHALL clear o_Overrun and o_Frame_Err only.
REQ-023 A start bit SHALL be accepted in the sample immediately following a stop sample (back-to-back frames).

Reset
REQ-024 Asserting i_Reset_n low SHALL immediately force IDLE, counter 0, shift register 0, o_Data=0, o_Ready=0, o_Busy=0, o_Overrun=0, o_Frame_Err=0.
REQ-025 Reset mid-frame SHALL discard the partial byte; reception restarts on the next start bit after release.

Configuration
REQ-026 Macro RXDATREG_PARITY_EN SHALL, when defined, add state PARITY (one even-parity bit after data) and output o_Parity_Err (output, 1, sticky, cleared like o_Frame_Err, reset 0).
REQ-027 With RXDATREG_PARITY_EN defined, a parity mismatch SHALL set o_Parity_Err but still load the byte per REQ-018/019.
REQ-028 Without RXDATREG_PARITY_EN, there SHALL be no PARITY state and no o_Parity_Err port; frame = start + DATA_W + stop.

Structure
REQ-029 Package usrt_pkg SHALL hold the receiver state enum, default DATA_W, and idle/start/stop line-level constants, shared with the transmit side.
REQ-030 Sub-module rxshift SHALL hold the shift register and bit counter, with shift-enable, clear and done outputs; rxdatreg holds FSM and holding register.

Verification
REQ-031 Reset, then frame of 8'b01010011 with stop=1 -> o_Ready=1 one cycle after stop sample, o_Data=8'h53, o_Busy=0.
REQ-032 Second frame 8'b11100110 without i_Read -> o_Overrun=1, o_Data remains 8'h53; i_Read -> o_Ready=0, o_Overrun=0.
REQ-033 Frame 8'b00001110 with stop=0 -> o_Frame_Err=1, o_Ready=0, o_Data unchanged.
REQ-034 i_Read pulsed in the completion cycle of 8'hA5 while holding 8'h53 -> o_Data=8'hA5, o_Ready=1, o_Overrun=0.
REQ-035 i_Reset_n low after 4 data bits of 8'h3C -> all outputs 0 immediately; next full frame 8'h3C received correctly.
REQ-036 With RXDATREG_PARITY_EN, 8'h53 with parity bit 1 (wrong, even) -> o_Parity_Err=1, o_Data=8'h53, o_Ready=1.

Source files
------------

// File: rtl/usrt_pkg.sv
// -----------------------------------------------------------------------------
// usrt_pkg
// Shared definitions for the USRT receive and transmit paths: receiver state
// encoding, default frame width and serial line levels.
//
// Configuration macro: RXDATREG_PARITY_EN adds the PARITY receiver state.
// -----------------------------------------------------------------------------
package usrt_pkg;

    // Default number of data bits per frame.
    localparam int DATA_W_DEF = 8;

    // Serial line levels.
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    // Receiver frame-tracking states.
`ifdef RXDATREG_PARITY_EN
    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;
`else
    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_DATA = 2'd1,
        RX_STOP = 2'd3
    } rx_state_t;
`endif

endpackage : usrt_pkg

// File: rtl/rxshift.sv
// -----------------------------------------------------------------------------
// rxshift
// Receive shift register and bit counter. Bits enter at the MSB and move
// toward the LSB, so the first (least significant) bit on the line ends up in
// bit 0 after DATA_W shifts.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   shift_en - shift bit_in in and advance the counter this cycle
//   clear    - zero the shift register and counter (start of a new frame)
//   bit_in   - sampled serial bit
//   data     - assembled data bits
//   done     - high in the cycle the last data bit is being shifted in
// -----------------------------------------------------------------------------
module rxshift #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en,
    input  logic              clear,
    input  logic              bit_in,
    output logic [DATA_W-1:0] data,
    output logic              done
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic [CNT_W-1:0] cnt;

    assign done = shift_en && (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            data <= '0;
        end else if (clear) begin
            cnt  <= '0;
            data <= '0;
        end else if (shift_en) begin
            data <= {bit_in, data[DATA_W-1:1]};
            cnt  <= done ? '0 : cnt + 1'b1;
        end
    end

endmodule : rxshift

// File: rtl/rxdatreg.sv
// -----------------------------------------------------------------------------
// rxdatreg
// USRT receive data register: frames serial data sampled on i_Sclk_En strobes
// (start, DATA_W data bits LSB first, optional even parity, stop) and holds the
// last accepted byte for the host with ready/overrun/error status.
//
// Configuration macro: RXDATREG_PARITY_EN adds an even-parity bit after the
// data bits and the o_Parity_Err output.
//
// Ports:
//   i_Pclk       - system clock, rising edge
//   i_Reset_n    - asynchronous active-low reset
//   i_Sclk_En    - one-cycle bit-sample strobe
//   i_Rx         - serial line, idle high
//   i_Read       - one-cycle host read strobe
//   o_Data       - last accepted byte
//   o_Ready      - o_Data holds an unread byte
//   o_Busy       - frame reception in progress
//   o_Overrun    - sticky: a completed byte was dropped
//   o_Frame_Err  - sticky: stop bit sampled low
//   o_Parity_Err - sticky: parity mismatch (RXDATREG_PARITY_EN only)
// -----------------------------------------------------------------------------
module rxdatreg
    import usrt_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_Pclk,
    input  logic              i_Reset_n,
    input  logic              i_Sclk_En,
    input  logic              i_Rx,
    input  logic              i_Read,
    output logic [DATA_W-1:0] o_Data,
    output logic              o_Ready,
    output logic              o_Busy,
    output logic              o_Overrun,
`ifdef RXDATREG_PARITY_EN
    output logic              o_Parity_Err,
`endif
    output logic              o_Frame_Err
);

    rx_state_t         state, state_nxt;
    logic              shift_en;
    logic              shift_clear;
    logic              shift_done;
    logic [DATA_W-1:0] shift_data;
    logic              stop_ok;
    logic              stop_bad;

    rxshift #(.DATA_W(DATA_W)) u_rxshift (
        .clk      (i_Pclk),
        .rst_n    (i_Reset_n),
        .shift_en (shift_en),
        .clear    (shift_clear),
        .bit_in   (i_Rx),
        .data     (shift_data),
        .done     (shift_done)
    );

    // ---------------- state register ----------------
    always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
        if (!i_Reset_n) state <= RX_IDLE;
        else            state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        if (i_Sclk_En) begin
            unique case (state)
                RX_IDLE: if (i_Rx == LINE_START) state_nxt = RX_DATA;
`ifdef RXDATREG_PARITY_EN
                RX_DATA:   if (shift_done) state_nxt = RX_PARITY;
                RX_PARITY: state_nxt = RX_STOP;
`else
                RX_DATA: if (shift_done) state_nxt = RX_STOP;
`endif
                RX_STOP: state_nxt = RX_IDLE;
                default: state_nxt = RX_IDLE;
            endcase
        end
    end

    // ---------------- output / strobe logic ----------------
    always_comb begin
        shift_en    = 1'b0;
        shift_clear = 1'b0;
        stop_ok     = 1'b0;
        stop_bad    = 1'b0;
        o_Busy      = (state != RX_IDLE);
        if (i_Sclk_En) begin
            shift_en    = (state == RX_DATA);
            shift_clear = (state == RX_IDLE) && (i_Rx == LINE_START);
            stop_ok     = (state == RX_STOP) && (i_Rx == LINE_STOP);
            stop_bad    = (state == RX_STOP) && (i_Rx != LINE_STOP);
        end
    end

`ifdef RXDATREG_PARITY_EN
    // Parity result for the frame in flight; it is only reported when the
    // frame completes with a good stop bit, alongside the delivered byte.
    logic par_bad;

    always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
        if (!i_Reset_n)
            par_bad <= 1'b0;
        else if (shift_clear)
            par_bad <= 1'b0;
        else if (i_Sclk_En && state == RX_PARITY)
            par_bad <= (^shift_data) ^ i_Rx;
    end

    always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
        if (!i_Reset_n)
            o_Parity_Err <= 1'b0;
        else if (stop_ok && par_bad)
            o_Parity_Err <= 1'b1;
        else if (i_Read)
            o_Parity_Err <= 1'b0;
    end
`endif

    // ---------------- holding register and status ----------------
    // A read clears the sticky flags first; events from a frame ending in the
    // same cycle are assigned later in the block and therefore win.
    always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_Data      <= '0;
            o_Ready     <= 1'b0;
            o_Overrun   <= 1'b0;
            o_Frame_Err <= 1'b0;
        end else begin
            if (i_Read) begin
                o_Ready     <= 1'b0;
                o_Overrun   <= 1'b0;
                o_Frame_Err <= 1'b0;
            end
            if (stop_ok) begin
                if (!o_Ready || i_Read) begin
                    o_Data  <= shift_data;
                    o_Ready <= 1'b1;
                end else begin
                    o_Overrun <= 1'b1;
                end
            end
            if (stop_bad)
                o_Frame_Err <= 1'b1;
        end
    end

endmodule : rxdatreg

// File: tb/tb_rxdatreg.sv
// -----------------------------------------------------------------------------
// tb_rxdatreg
// Directed testbench for rxdatreg. Define RXDATREG_PARITY_EN to exercise the
// parity build as well.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rxdatreg;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sclk_en = 1'b0;
    logic              rx = 1'b1;
    logic              rd = 1'b0;
    logic [DATA_W-1:0] data;
    logic              ready;
    logic              busy;
    logic              overrun;
    logic              frame_err;
`ifdef RXDATREG_PARITY_EN
    logic              parity_err;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    rxdatreg #(.DATA_W(DATA_W)) dut (
        .i_Pclk       (clk),
        .i_Reset_n    (rst_n),
        .i_Sclk_En    (sclk_en),
        .i_Rx         (rx),
        .i_Read       (rd),
        .o_Data       (data),
        .o_Ready      (ready),
        .o_Busy       (busy),
        .o_Overrun    (overrun),
`ifdef RXDATREG_PARITY_EN
        .o_Parity_Err (parity_err),
`endif
        .o_Frame_Err  (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bit-sample strobe; returns on the falling edge after the sampling
    // rising edge, so registered outputs already reflect the sample.
    task automatic sample_bit(input logic b, input logic with_read);
        @(negedge clk);
        rx      = b;
        sclk_en = 1'b1;
        rd      = with_read;
        @(negedge clk);
        sclk_en = 1'b0;
        rd      = 1'b0;
        rx      = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] byte_v, input logic stop_v,
                              input logic par_v, input logic read_on_stop);
        sample_bit(1'b0, 1'b0);
        check("busy_after_start", busy, 1);
        for (int i = 0; i < DATA_W; i++) sample_bit(byte_v[i], 1'b0);
`ifdef RXDATREG_PARITY_EN
        sample_bit(par_v, 1'b0);
`endif
        sample_bit(stop_v, read_on_stop);
    endtask

    task automatic host_read();
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_data", data, 8'h00);
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_frame_err", frame_err, 0);
        rst_n = 1'b1;

        // Line activity without the sample strobe is ignored
        @(negedge clk); rx = 1'b0;
        repeat (3) @(negedge clk);
        check("no_strobe_busy", busy, 0);
        rx = 1'b1;

        // First frame 0x53
        send_frame(8'b0101_0011, 1'b1, 1'b0, 1'b0);
        check("f1_ready", ready, 1);
        check("f1_data", data, 8'h53);
        check("f1_busy", busy, 0);
`ifdef RXDATREG_PARITY_EN
        check("f1_parity_err", parity_err, 0);
`endif

        // Second frame 0xE6 back-to-back, unread: overrun, old byte kept
        send_frame(8'b1110_0110, 1'b1, 1'b1, 1'b0);
        check("f2_overrun", overrun, 1);
        check("f2_data_kept", data, 8'h53);
        check("f2_ready", ready, 1);
        host_read();
        check("rd1_ready", ready, 0);
        check("rd1_overrun", overrun, 0);
        check("rd1_data", data, 8'h53);

        // Bad stop bit: frame error, byte discarded
        send_frame(8'b0000_1110, 1'b0, 1'b1, 1'b0);
        check("f3_frame_err", frame_err, 1);
        check("f3_ready", ready, 0);
        check("f3_data", data, 8'h53);
        host_read();
        check("rd2_frame_err", frame_err, 0);
        check("rd2_data", data, 8'h53);

        // Hold 0x53, then read in the completion cycle of 0xA5
        send_frame(8'h53, 1'b1, 1'b0, 1'b0);
        check("f4_ready", ready, 1);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        check("f5_data", data, 8'hA5);
        check("f5_ready", ready, 1);
        check("f5_overrun", overrun, 0);

        // Read coinciding with a bad-stop completion: error of new frame wins
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        check("f6_frame_err", frame_err, 1);
        check("f6_ready", ready, 0);
        check("f6_data", data, 8'hA5);

        // Reset mid-frame after 4 data bits of 0x3C
        sample_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) sample_bit(8'h3C >> i, 1'b0);
        check("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_data", data, 8'h00);
        check("arst_ready", ready, 0);
        check("arst_busy", busy, 0);
        check("arst_frame_err", frame_err, 0);
        check("arst_overrun", overrun, 0);
        @(negedge clk); rst_n = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        check("f7_data", data, 8'h3C);
        check("f7_ready", ready, 1);
        check("f7_frame_err", frame_err, 0);

`ifdef RXDATREG_PARITY_EN
        // Wrong even parity still delivers the byte
        host_read();
        send_frame(8'h53, 1'b1, 1'b1, 1'b0);
        check("fp_parity_err", parity_err, 1);
        check("fp_data", data, 8'h53);
        check("fp_ready", ready, 1);
        host_read();
        check("fp_rd_parity_err", parity_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_rxdatreg
